// File: rtl/countdown_clock.sv
// MM:SS packed-BCD countdown timer driven by a one-second tick, with load, pause and expiry signalling.
// Optional penalty input and logic are enabled by defining COUNTDOWN_PENALTY_EN.
module countdown_clock #(
   parameter logic [7:0] INIT_MIN    = 8'h05,
   parameter logic [7:0] INIT_SEC    = 8'h00,
   parameter int         LOW_THRESH  = 10,
   parameter int         PENALTY_SEC = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
`ifdef COUNTDOWN_PENALTY_EN
   input  logic       penalty,
`endif
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       expired,
   output logic       expired_pulse,
   output logic       low_time,
   output logic       load_err
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t      state;
   logic [6:0]  step;
   logic [7:0]  dec_min;
   logic [7:0]  dec_sec;
   logic        dec_zero;
   logic        dec_low;
   logic        load_ok;
   logic        load_low;
   logic        time_zero;

   function automatic logic [6:0] bcd2bin(input logic [7:0] b);
      return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
   endfunction

   function automatic logic [7:0] bin2bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   function automatic logic is_low(input logic [7:0] m, input logic [7:0] s);
      logic [12:0] total;
      total = (13'(bcd2bin(m)) * 13'd60) + 13'(bcd2bin(s));
      return (total != 13'd0) && (total <= 13'(LOW_THRESH));
   endfunction

   // Subtracting up to 60 s borrows at most one minute, and an underflow saturates at 00:00.
   function automatic logic [15:0] sub_time(input logic [7:0] m, input logic [7:0] s,
                                            input logic [6:0] d);
      logic [6:0] mb;
      logic [6:0] sb;
      mb = bcd2bin(m);
      sb = bcd2bin(s);
      if (sb >= d) begin
         sb = sb - d;
      end else if (mb != 7'd0) begin
         mb = mb - 7'd1;
         sb = sb + 7'd60 - d;
      end else begin
         mb = 7'd0;
         sb = 7'd0;
      end
      return {bin2bcd(mb), bin2bcd(sb)};
   endfunction

`ifdef COUNTDOWN_PENALTY_EN
   always_comb begin
      step = 7'd0;
      if (state == RUN) begin
         step = {6'd0, tick} + (penalty ? 7'(PENALTY_SEC) : 7'd0);
      end else if (state == PAUSED && penalty) begin
         step = 7'(PENALTY_SEC);
      end
   end
`else
   always_comb begin
      step = 7'd0;
      if (state == RUN && tick) begin
         step = 7'd1;
      end
   end
`endif

   always_comb begin
      {dec_min, dec_sec} = sub_time(min_bcd, sec_bcd, step);
      dec_zero  = (dec_min == 8'h00) && (dec_sec == 8'h00);
      dec_low   = is_low(dec_min, dec_sec);
      time_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
      load_ok   = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                  (load_sec[3:0] <= 4'd9) && (load_sec <= 8'h59);
      load_low  = is_low(load_min, load_sec);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         min_bcd       <= INIT_MIN;
         sec_bcd       <= INIT_SEC;
         running       <= 1'b0;
         expired       <= 1'b0;
         expired_pulse <= 1'b0;
         load_err      <= 1'b0;
         low_time      <= is_low(INIT_MIN, INIT_SEC);
      end else begin
         expired_pulse <= 1'b0;
         load_err      <= 1'b0;
         // Load outranks every other input, but is simply not seen while running.
         if (load && state != RUN) begin
            if (load_ok) begin
               min_bcd  <= load_min;
               sec_bcd  <= load_sec;
               low_time <= load_low;
               if (state == EXPIRED) begin
                  state   <= IDLE;
                  expired <= 1'b0;
               end
            end else begin
               load_err <= 1'b1;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (!pause && start) begin
                     if (time_zero) begin
                        state         <= EXPIRED;
                        expired       <= 1'b1;
                        expired_pulse <= 1'b1;
                     end else begin
                        state   <= RUN;
                        running <= 1'b1;
                     end
                  end
               end
               RUN, PAUSED: begin
                  if (state == RUN && pause) begin
                     state   <= PAUSED;
                     running <= 1'b0;
                  end else if (state == PAUSED && !pause && start) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end else if (!pause && step != 7'd0) begin
                     min_bcd  <= dec_min;
                     sec_bcd  <= dec_sec;
                     low_time <= dec_low;
                     if (dec_zero) begin
                        state         <= EXPIRED;
                        running       <= 1'b0;
                        expired       <= 1'b1;
                        expired_pulse <= 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
